coproc_cmd_ctrl: RTL and testbench
==================================

// Module: coproc_cmd_ctrl
// PURPOSE
//  Command-side controller that drives the matrix coprocessor. It accepts 32-bit commands from the HPS bridge.
//  It loads the A and B operand registers one element at a time, then issues an operation.
//  It waits a programmable settle time for the combinational datapath, captures the result, and streams it back
//  element by element over a valid/ready response channel.
// PARAMETERS
//  ELEM_W        8   element width in bits
//  MAX_DIM       5   maximum matrix dimension; operand bus = ELEM_W*MAX_DIM*MAX_DIM (200)
//  SETTLE_CYCLES 2   cycles op_code is held before result capture (1..15)
// PORTS
//  clk            in   1    system clock
//  reset          in   1    asynchronous reset, active-high
//  cmd_valid      in   1    command word valid
//  cmd_ready      out  1    controller accepts command this cycle
//  cmd_data       in   32   command word (format below)
//  rsp_valid      out  1    response element valid
//  rsp_ready      in   1    host consumes response element
//  rsp_data       out  8    result element
//  rsp_last       out  1    marks final element of a READ stream
//  cmd_error      out  1    sticky error flag
//  op_code        out  3    to coprocessor: operation select
//  matrix_size    out  2    to coprocessor: 00=2x2,01=3x3,10=4x4,11=5x5
//  matrix_a       out  200  to coprocessor: operand A register
//  matrix_b       out  200  to coprocessor: operand B register
//  process_Done   in   1    from coprocessor: operation valid
//  result_final   in   200  from coprocessor: result bus
// BEHAVIOUR
//  Layout: element (r,c) occupies bits [8*(5r+c)+7 : 8*(5r+c)] of every 200-bit bus. N = matrix_size+2.
//  Command [31:29]: 000 NOP; 001 LOAD_A; 010 LOAD_B; 011 EXEC; 100 READ; 111 CLEAR; others are illegal.
//  LOAD_x: [28:24] index 0..24; [7:0] value.
//    Index >24: the command sets cmd_error and writes nothing.
//    Indices outside NxN are legal and are stored.
//  EXEC: [4:2] op code; [1:0] size.
//  Reset (async): state IDLE; all registers 0, including matrix_a/b, the result register and result_ok.
//    All outputs are 0 while reset is high, including cmd_ready.
//    cmd_ready rises on the first clk edge after reset deasserts.
//  Handshakes:
//    A command transfers on cmd_valid&cmd_ready.
//    A response transfers on rsp_valid&rsp_ready.
//    rsp_data and rsp_last are stable while rsp_valid&!rsp_ready.
//  States:
//   IDLE: cmd_ready=1; op_code=0.
//     LOAD/NOP/CLEAR complete in the accept cycle and the state stays in IDLE.
//     CLEAR zeroes A, B, the result register, result_ok and cmd_error.
//     EXEC latches op/size, loads the settle counter with SETTLE_CYCLES, and goes to SETTLE.
//     READ goes to STREAM if result_ok=1. If result_ok=0 it sets cmd_error and stays in IDLE.
//     An illegal class sets cmd_error and stays in IDLE.
//   SETTLE: cmd_ready=0; op_code and matrix_size driven from the latched values.
//     The counter decrements each cycle. When it reaches 0, go to CAPTURE.
//   CAPTURE (1 cycle): op_code still driven.
//     If process_Done=1: register result_final and set result_ok=1.
//     Otherwise: set result_ok=0 and cmd_error=1.
//     Go to IDLE; op_code returns to 0 in IDLE.
//   STREAM: rsp_valid=1. Row/col counters start at (0,0) and emit the NxN elements row-major, skipping the padding.
//     On each handshake the column increments; when col=N-1 the column wraps to 0 and the row increments.
//     rsp_last=1 on element (N-1,N-1). Its handshake returns the state to IDLE.
//     N is taken from the size latched at EXEC.
//  Latency:
//    EXEC accept -> CAPTURE takes SETTLE_CYCLES+1 cycles.
//    The first rsp_valid comes 1 cycle after READ is accepted.
//  The result register holds until the next EXEC or CLEAR, so repeated READs re-stream the same data.
//  A new EXEC always rewrites result_ok.
//  Loads never disturb a captured result.
//  matrix_a and matrix_b change only on a LOAD or CLEAR; they are stable throughout SETTLE and CAPTURE.
//  cmd_error is sticky: cleared only by reset or CLEAR.
//  Reset mid-STREAM or mid-SETTLE: immediate return to the reset state. No partial response is completed.
// TESTING
//  1 Reset: hold reset 3 cycles -> cmd_ready=0, rsp_valid=0, matrix_a=0; cmd_ready=1 one edge after release.
//  2 Load + EXEC: LOAD_A idx0=0x05, LOAD_B idx0=0x03, EXEC op=111 size=00 (SETTLE_CYCLES=2).
//    Expect op_code=111 for exactly 3 cycles, then result register = result_final, cmd_error=0.
//  3 READ 3x3 after an EXEC with size=01: expect exactly 9 beats (indices 0,1,2,5,6,7,10,11,12) with rsp_last on the 9th.
//    Toggle rsp_ready every other cycle: rsp_data must hold while stalled.
//  4 EXEC op=000 (process_Done=0): expect cmd_error=1 after CAPTURE.
//    A following READ sets no rsp_valid and keeps cmd_error=1.
//  5 Error paths: LOAD_A idx=25 -> matrix_a unchanged, cmd_error=1; class 101 -> cmd_error=1; CLEAR -> cmd_error=0.
//  6 Assert reset during beat 4 of a 5x5 READ: rsp_valid drops immediately.
//    After release, READ -> cmd_error=1 (result_ok cleared).

Source files
------------

// File: rtl/coproc_cmd_ctrl.sv
// Command-side controller for the matrix coprocessor: loads operands, issues an
// operation, waits a settle time, captures the result and streams it back.
module coproc_cmd_ctrl #(
   parameter int ELEM_W        = 8,
   parameter int MAX_DIM       = 5,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              cmd_valid,
   output logic                              cmd_ready,
   input  logic [31:0]                       cmd_data,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic [ELEM_W-1:0]                 rsp_data,
   output logic                              rsp_last,
   output logic                              cmd_error,
   output logic [2:0]                        op_code,
   output logic [1:0]                        matrix_size,
   output logic [ELEM_W*MAX_DIM*MAX_DIM-1:0] matrix_a,
   output logic [ELEM_W*MAX_DIM*MAX_DIM-1:0] matrix_b,
   input  logic                              process_Done,
   input  logic [ELEM_W*MAX_DIM*MAX_DIM-1:0] result_final
);

   localparam int BUS_W    = ELEM_W * MAX_DIM * MAX_DIM;
   localparam int NUM_ELEM = MAX_DIM * MAX_DIM;

   localparam logic [2:0] CLS_NOP    = 3'b000;
   localparam logic [2:0] CLS_LOAD_A = 3'b001;
   localparam logic [2:0] CLS_LOAD_B = 3'b010;
   localparam logic [2:0] CLS_EXEC   = 3'b011;
   localparam logic [2:0] CLS_READ   = 3'b100;
   localparam logic [2:0] CLS_CLEAR  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_CAPTURE,
      ST_STREAM
   } state_t;

   state_t             r_state;
   state_t             w_nextState;
   logic               r_alive;
   logic [3:0]         r_settleCnt;
   logic [2:0]         r_op;
   logic [1:0]         r_size;
   logic [BUS_W-1:0]   r_matA;
   logic [BUS_W-1:0]   r_matB;
   logic [BUS_W-1:0]   r_result;
   logic               r_resultOk;
   logic               r_error;
   logic [2:0]         r_row;
   logic [2:0]         r_col;

   logic               w_cmdFire;
   logic               w_rspFire;
   logic [2:0]         w_class;
   logic [4:0]         w_loadIdx;
   logic [ELEM_W-1:0]  w_loadVal;
   logic               w_idxOk;
   logic [2:0]         w_dimLast;
   logic               w_lastCol;
   logic               w_lastRow;
   logic [4:0]         w_elemIdx;
   logic               w_unused;

   assign w_class   = cmd_data[31:29];
   assign w_loadIdx = cmd_data[28:24];
   assign w_loadVal = cmd_data[ELEM_W-1:0];
   assign w_idxOk   = (w_loadIdx < 5'(NUM_ELEM));
   assign w_cmdFire = cmd_valid & cmd_ready;
   assign w_rspFire = rsp_valid & rsp_ready;
   assign w_unused  = &{1'b0, cmd_data[23:ELEM_W]};

   // Stream geometry: N-1 from the latched size, element index row-major in the padded bus
   assign w_dimLast = {1'b0, r_size} + 3'd1;
   assign w_lastCol = (r_col == w_dimLast);
   assign w_lastRow = (r_row == w_dimLast);
   assign w_elemIdx = 5'(MAX_DIM) * {2'b00, r_row} + {2'b00, r_col};

   assign cmd_error   = r_error;
   assign matrix_size = r_size;
   assign matrix_a    = r_matA;
   assign matrix_b    = r_matB;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and handshake/output decode; cmd_ready waits one edge after reset
   always_comb begin
      w_nextState = r_state;
      cmd_ready   = 1'b0;
      rsp_valid   = 1'b0;
      rsp_last    = 1'b0;
      rsp_data    = '0;
      op_code     = 3'b000;
      case (r_state)
         ST_IDLE: begin
            cmd_ready = r_alive;
            if (cmd_valid && r_alive) begin
               if (w_class == CLS_EXEC) begin
                  w_nextState = ST_SETTLE;
               end else if (w_class == CLS_READ && r_resultOk) begin
                  w_nextState = ST_STREAM;
               end
            end
         end
         ST_SETTLE: begin
            op_code = r_op;
            if (r_settleCnt <= 4'd1) begin
               w_nextState = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            op_code     = r_op;
            w_nextState = ST_IDLE;
         end
         ST_STREAM: begin
            rsp_valid = 1'b1;
            rsp_last  = w_lastRow & w_lastCol;
            rsp_data  = r_result[int'(w_elemIdx)*ELEM_W +: ELEM_W];
            if (rsp_ready && w_lastRow && w_lastCol) begin
               w_nextState = ST_IDLE;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // Ready enable and operation latches
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_alive     <= 1'b0;
         r_op        <= 3'b000;
         r_size      <= 2'b00;
         r_settleCnt <= 4'd0;
      end else begin
         r_alive <= 1'b1;
         if (w_cmdFire && w_class == CLS_EXEC) begin
            r_op        <= cmd_data[4:2];
            r_size      <= cmd_data[1:0];
            r_settleCnt <= 4'(SETTLE_CYCLES);
         end else if (r_state == ST_SETTLE) begin
            r_settleCnt <= r_settleCnt - 4'd1;
         end
      end
   end

   // Operand registers: only LOAD and CLEAR touch them, so they are frozen during SETTLE/CAPTURE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_matA <= '0;
         r_matB <= '0;
      end else if (w_cmdFire) begin
         if (w_class == CLS_CLEAR) begin
            r_matA <= '0;
            r_matB <= '0;
         end else if (w_class == CLS_LOAD_A && w_idxOk) begin
            r_matA[int'(w_loadIdx)*ELEM_W +: ELEM_W] <= w_loadVal;
         end else if (w_class == CLS_LOAD_B && w_idxOk) begin
            r_matB[int'(w_loadIdx)*ELEM_W +: ELEM_W] <= w_loadVal;
         end
      end
   end

   // Captured result and its validity; a failed capture invalidates any older result
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_result   <= '0;
         r_resultOk <= 1'b0;
      end else if (w_cmdFire && w_class == CLS_CLEAR) begin
         r_result   <= '0;
         r_resultOk <= 1'b0;
      end else if (r_state == ST_CAPTURE) begin
         if (process_Done) begin
            r_result   <= result_final;
            r_resultOk <= 1'b1;
         end else begin
            r_resultOk <= 1'b0;
         end
      end
   end

   // Sticky error flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_error <= 1'b0;
      end else if (w_cmdFire) begin
         case (w_class)
            CLS_CLEAR:  r_error <= 1'b0;
            CLS_NOP,
            CLS_EXEC:   r_error <= r_error;
            CLS_LOAD_A,
            CLS_LOAD_B: r_error <= r_error | ~w_idxOk;
            CLS_READ:   r_error <= r_error | ~r_resultOk;
            default:    r_error <= 1'b1;
         endcase
      end else if (r_state == ST_CAPTURE && !process_Done) begin
         r_error <= 1'b1;
      end
   end

   // Row/column walk over the NxN window
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_row <= 3'd0;
         r_col <= 3'd0;
      end else if (w_cmdFire && w_class == CLS_READ) begin
         r_row <= 3'd0;
         r_col <= 3'd0;
      end else if (w_rspFire) begin
         if (w_lastCol) begin
            r_col <= 3'd0;
            r_row <= r_row + 3'd1;
         end else begin
            r_col <= r_col + 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_coproc_cmd_ctrl.sv
// Self-checking bench for coproc_cmd_ctrl: scoreboard of expected response
// elements filled when a READ is issued and drained on each response handshake.
module tb_coproc_cmd_ctrl;

   localparam int SETTLE = 2;

   logic         clk          = 1'b0;
   logic         reset        = 1'b0;
   logic         cmd_valid    = 1'b0;
   logic [31:0]  cmd_data     = 32'h0;
   logic         rsp_ready    = 1'b0;
   logic         process_Done = 1'b0;
   logic [199:0] result_final = '0;

   logic         cmd_ready;
   logic         rsp_valid;
   logic [7:0]   rsp_data;
   logic         rsp_last;
   logic         cmd_error;
   logic [2:0]   op_code;
   logic [1:0]   matrix_size;
   logic [199:0] matrix_a;
   logic [199:0] matrix_b;

   int compared   = 0;
   int mismatched = 0;

   logic [7:0]   sbData[$];
   logic         sbLast[$];
   logic [199:0] modelResult = '0;
   logic [199:0] modelA      = '0;
   logic [199:0] modelB      = '0;

   coproc_cmd_ctrl #(.ELEM_W(8), .MAX_DIM(5), .SETTLE_CYCLES(SETTLE)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
      .cmd_error(cmd_error), .op_code(op_code), .matrix_size(matrix_size),
      .matrix_a(matrix_a), .matrix_b(matrix_b),
      .process_Done(process_Done), .result_final(result_final)
   );

   always #5 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [199:0] makePattern(input int seed);
      logic [199:0] p;
      p = '0;
      for (int i = 0; i < 25; i++) p[8*i +: 8] = 8'(i * seed + 17);
      return p;
   endfunction

   function automatic logic [31:0] cmdLoad(input logic [2:0] cls, input logic [4:0] idx,
                                           input logic [7:0] val);
      return {cls, idx, 16'h0000, val};
   endfunction

   function automatic logic [31:0] cmdExec(input logic [2:0] op, input logic [1:0] size);
      return {3'b011, 24'h000000, op, size};
   endfunction

   task automatic pushExpected(input int n);
      for (int r = 0; r < n; r++)
         for (int c = 0; c < n; c++) begin
            sbData.push_back(modelResult[8*(5*r+c) +: 8]);
            sbLast.push_back((r == n-1) && (c == n-1));
         end
   endtask

   task automatic sendCmd(input logic [31:0] word);
      int waitCycles;
      waitCycles = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_data  = word;
      while (cmd_ready !== 1'b1 && waitCycles < 50) begin
         @(negedge clk);
         waitCycles++;
      end
      if (cmd_ready !== 1'b1) begin
         compared++; mismatched++;
         $display("[TB] FAIL cmd_accept: got cmd_ready=%b expected 1 within 50 cycles", cmd_ready);
      end else begin
         @(posedge clk);
      end
      #1;
      cmd_valid = 1'b0;
      cmd_data  = 32'h0;
   endtask

   // readyMode 0: always ready; 1: ready every other cycle. abortAfter>0 asserts reset after that many beats.
   task automatic runRead(input int readyMode, input int abortAfter, input int n);
      int cyc, beats;
      logic stalledPrev, heldLast, expLast, newReady, aborted;
      logic [7:0] heldData, expData;
      cyc = 0; beats = 0; stalledPrev = 1'b0; aborted = 1'b0;
      heldData = 8'h0; heldLast = 1'b0;
      pushExpected(n);
      sendCmd(32'h8000_0000);
      @(negedge clk);
      compared++;
      if (rsp_valid !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL read_latency: got rsp_valid=%b expected 1", rsp_valid);
      end
      while (sbData.size() > 0 && cyc < 200) begin
         if (abortAfter > 0 && beats == abortAfter) begin
            reset = 1'b1;
            #1;
            compared++;
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
               mismatched++;
               $display("[TB] FAIL reset_abort: got rsp_valid=%b cmd_ready=%b expected 0 0",
                        rsp_valid, cmd_ready);
            end
            sbData.delete();
            sbLast.delete();
            aborted = 1'b1;
            break;
         end
         if (stalledPrev) begin
            compared++;
            if (rsp_valid !== 1'b1 || rsp_data !== heldData || rsp_last !== heldLast) begin
               mismatched++;
               $display("[TB] FAIL stall_hold: got valid=%b data=%h last=%b expected 1 %h %b",
                        rsp_valid, rsp_data, rsp_last, heldData, heldLast);
            end
         end
         newReady  = (readyMode == 0) ? 1'b1 : 1'(cyc % 2);
         rsp_ready = newReady;
         if (rsp_valid === 1'b1 && newReady) begin
            expData = sbData.pop_front();
            expLast = sbLast.pop_front();
            compared++;
            if (rsp_data !== expData || rsp_last !== expLast) begin
               mismatched++;
               $display("[TB] FAIL beat%0d: got data=%h last=%b expected %h %b",
                        beats, rsp_data, rsp_last, expData, expLast);
            end
            beats++;
         end
         stalledPrev = (rsp_valid === 1'b1) && !newReady;
         heldData    = rsp_data;
         heldLast    = rsp_last;
         cyc++;
         @(negedge clk);
      end
      rsp_ready = 1'b0;
      if (!aborted) begin
         compared++;
         if (sbData.size() != 0 || beats != n*n) begin
            mismatched++;
            $display("[TB] FAIL beat_count: got %0d expected %0d", beats, n*n);
            sbData.delete();
            sbLast.delete();
         end
         compared++;
         if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL stream_end: got rsp_valid=%b cmd_ready=%b expected 0 1",
                     rsp_valid, cmd_ready);
         end
      end
   endtask

   task automatic test_reset();
      #2 reset = 1'b1;
      repeat (3) @(negedge clk);
      compared++;
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || matrix_a !== '0 || op_code !== 3'b000
          || cmd_error !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_state: got ready=%b valid=%b a_zero=%b op=%b err=%b expected 0 0 1 000 0",
                  cmd_ready, rsp_valid, matrix_a == '0, op_code, cmd_error);
      end
      reset = 1'b0;
      #1;
      compared++;
      if (cmd_ready !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL ready_before_edge: got %b expected 0", cmd_ready);
      end
      @(negedge clk);
      compared++;
      if (cmd_ready !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL ready_after_edge: got %b expected 1", cmd_ready);
      end
   endtask

   task automatic test_exec();
      int opCycles;
      sendCmd(cmdLoad(3'b001, 5'd0, 8'h05)); modelA[7:0] = 8'h05;
      sendCmd(cmdLoad(3'b010, 5'd0, 8'h03)); modelB[7:0] = 8'h03;
      @(negedge clk);
      compared++;
      if (matrix_a !== modelA || matrix_b !== modelB) begin
         mismatched++;
         $display("[TB] FAIL load_ab: got a0=%h b0=%h expected %h %h",
                  matrix_a[7:0], matrix_b[7:0], modelA[7:0], modelB[7:0]);
      end
      result_final = makePattern(7);
      process_Done = 1'b1;
      modelResult  = result_final;
      sendCmd(cmdExec(3'b111, 2'b00));
      opCycles = 0;
      repeat (8) begin
         @(negedge clk);
         if (op_code === 3'b111) opCycles++;
      end
      compared++;
      if (opCycles != SETTLE + 1) begin
         mismatched++;
         $display("[TB] FAIL op_hold: got %0d cycles expected %0d", opCycles, SETTLE + 1);
      end
      compared++;
      if (cmd_error !== 1'b0 || op_code !== 3'b000 || cmd_ready !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL exec_done: got err=%b op=%b ready=%b expected 0 000 1",
                  cmd_error, op_code, cmd_ready);
      end
      result_final = ~result_final;
      runRead(0, 0, 2);
   endtask

   task automatic test_read_3x3();
      result_final = makePattern(3);
      process_Done = 1'b1;
      modelResult  = result_final;
      sendCmd(cmdExec(3'b001, 2'b01));
      sendCmd(32'h0000_0000);
      result_final = makePattern(29);
      runRead(1, 0, 3);
      compared++;
      if (cmd_error !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL read3_err: got %b expected 0", cmd_error);
      end
   endtask

   task automatic test_back_to_back();
      sendCmd(cmdLoad(3'b001, 5'd7, 8'h99)); modelA[63:56] = 8'h99;
      runRead(0, 0, 3);
      compared++;
      if (matrix_a !== modelA) begin
         mismatched++;
         $display("[TB] FAIL load_keeps_result: got a7=%h expected %h", matrix_a[63:56], modelA[63:56]);
      end
   endtask

   task automatic test_exec_fail();
      logic sawValid;
      process_Done = 1'b0;
      sendCmd(cmdExec(3'b000, 2'b00));
      sendCmd(32'h0000_0000);
      @(negedge clk);
      compared++;
      if (cmd_error !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL exec_fail_err: got %b expected 1", cmd_error);
      end
      sendCmd(32'h8000_0000);
      sawValid = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0) sawValid = 1'b1;
      end
      compared++;
      if (sawValid !== 1'b0 || cmd_error !== 1'b1 || cmd_ready !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL read_no_result: got valid_seen=%b err=%b ready=%b expected 0 1 1",
                  sawValid, cmd_error, cmd_ready);
      end
   endtask

   task automatic test_errors();
      sendCmd(32'hE000_0000); modelA = '0; modelB = '0;
      @(negedge clk);
      compared++;
      if (cmd_error !== 1'b0 || matrix_a !== '0) begin
         mismatched++;
         $display("[TB] FAIL clear1: got err=%b a_zero=%b expected 0 1", cmd_error, matrix_a == '0);
      end
      sendCmd(cmdLoad(3'b001, 5'd3, 8'hAA));  modelA[31:24]   = 8'hAA;
      sendCmd(cmdLoad(3'b010, 5'd24, 8'h5C)); modelB[199:192] = 8'h5C;
      sendCmd(cmdLoad(3'b001, 5'd25, 8'h55));
      @(negedge clk);
      compared++;
      if (matrix_a !== modelA || matrix_b !== modelB || cmd_error !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL bad_index: got a3=%h b24=%h err=%b a_ok=%b expected aa 5c 1 1",
                  matrix_a[31:24], matrix_b[199:192], cmd_error, matrix_a == modelA);
      end
      sendCmd(32'hE000_0000); modelA = '0; modelB = '0;
      @(negedge clk);
      compared++;
      if (cmd_error !== 1'b0 || matrix_b !== '0) begin
         mismatched++;
         $display("[TB] FAIL clear2: got err=%b b_zero=%b expected 0 1", cmd_error, matrix_b == '0);
      end
      sendCmd(32'hA000_0000);
      @(negedge clk);
      compared++;
      if (cmd_error !== 1'b1 || cmd_ready !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL illegal_class: got err=%b ready=%b expected 1 1", cmd_error, cmd_ready);
      end
      sendCmd(32'hE000_0000);
      sendCmd(32'h8000_0000);
      @(negedge clk);
      compared++;
      if (cmd_error !== 1'b1 || rsp_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL read_after_clear: got err=%b valid=%b expected 1 0", cmd_error, rsp_valid);
      end
   endtask

   task automatic test_reset_mid_stream();
      logic sawValid;
      sendCmd(32'hE000_0000);
      sendCmd(cmdLoad(3'b001, 5'd0, 8'h42));
      result_final = makePattern(11);
      process_Done = 1'b1;
      modelResult  = result_final;
      sendCmd(cmdExec(3'b010, 2'b11));
      sendCmd(32'h0000_0000);
      runRead(0, 3, 5);
      repeat (2) @(negedge clk);
      compared++;
      if (matrix_a !== '0 || cmd_error !== 1'b0 || rsp_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL mid_reset_state: got a_zero=%b err=%b valid=%b expected 1 0 0",
                  matrix_a == '0, cmd_error, rsp_valid);
      end
      reset = 1'b0;
      @(negedge clk);
      compared++;
      if (cmd_ready !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL ready_after_mid_reset: got %b expected 1", cmd_ready);
      end
      sendCmd(32'h8000_0000);
      sawValid = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0) sawValid = 1'b1;
      end
      compared++;
      if (sawValid !== 1'b0 || cmd_error !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL read_after_reset: got valid_seen=%b err=%b expected 0 1", sawValid, cmd_error);
      end
   endtask

   initial begin
      test_reset();
      test_exec();
      test_read_3x3();
      test_back_to_back();
      test_exec_fail();
      test_errors();
      test_reset_mid_stream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
